// File: rtl/bolt_pkg.sv
// Shared constants and enums for the player bolt recall logic.
package bolt_pkg;
  localparam int NUM_BOLTS    = 4;
  localparam int COORD_W      = 11;
  localparam int SCREEN_TOP_Y = 8;

  typedef enum logic [1:0] {IDLE, FLYING, RETURN} bolt_slot_st_t;
  typedef enum logic [1:0] {NONE, ALIEN, SHIELD} hit_kind_t;
endpackage

// File: rtl/bolt_slot_fsm.sv
// One bolt slot: flight tracking, first-hit latch, and the recall handshake
// that is held for a fixed number of frames.
module bolt_slot_fsm
  import bolt_pkg::*;
#(
  parameter int TOP_LIMIT_Y   = SCREEN_TOP_Y,
  parameter int RETURN_FRAMES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               boltFired,
  input  logic [COORD_W-1:0] boltY,
  input  logic               drawBolt,
  input  logic               drawAlien,
  input  logic               drawShield,
  output logic               boltReturn,
  output logic               alienHit,
  output logic               shieldHit
);
  localparam int CNT_W = $clog2(RETURN_FRAMES + 1);

  bolt_slot_st_t    state_q, state_d;
  hit_kind_t        latch_q, latch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alien_q, alien_d;
  logic             shield_q, shield_d;
  logic             hit_a, hit_s, off_scr;

  // Alien wins when both are drawn on the bolt's pixel.
  assign hit_a   = drawBolt & drawAlien;
  assign hit_s   = drawBolt & drawShield & ~drawAlien;
  // Bit 10 set means a negative/wrapped Y, which is also off-screen.
  assign off_scr = boltY[COORD_W-1] | (boltY < COORD_W'(TOP_LIMIT_Y));

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    cnt_d    = cnt_q;
    alien_d  = 1'b0;
    shield_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOfFrame && boltFired) begin
          state_d = FLYING;
          latch_d = NONE;
        end
      end
      FLYING: begin
        if (latch_q == NONE) begin
          if (hit_a) begin
            latch_d = ALIEN;
            alien_d = 1'b1;
          end else if (hit_s) begin
            latch_d  = SHIELD;
            shield_d = 1'b1;
          end
        end
        if (startOfFrame && ((latch_q != NONE) || hit_a || hit_s || off_scr)) begin
          state_d = RETURN;
          cnt_d   = CNT_W'(RETURN_FRAMES);
        end
      end
      RETURN: begin
        if (startOfFrame) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      latch_q  <= NONE;
      cnt_q    <= '0;
      alien_q  <= 1'b0;
      shield_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      latch_q  <= latch_d;
      cnt_q    <= cnt_d;
      alien_q  <= alien_d;
      shield_q <= shield_d;
    end
  end

  assign boltReturn = (state_q == RETURN);
  assign alienHit   = alien_q;
  assign shieldHit  = shield_q;
endmodule

// File: rtl/bolt_return_ctrl.sv
// Recall controller for all player bolt slots; each slot is an independent FSM
// sharing the frame strobe and the alien/shield draw requests.
module bolt_return_ctrl #(
  parameter int NUM_BOLTS     = bolt_pkg::NUM_BOLTS,
  parameter int TOP_LIMIT_Y   = bolt_pkg::SCREEN_TOP_Y,
  parameter int RETURN_FRAMES = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   startOfFrame,
  input  logic [NUM_BOLTS-1:0]                   boltFired,
  input  logic [NUM_BOLTS*bolt_pkg::COORD_W-1:0] boltY,
  input  logic [NUM_BOLTS-1:0]                   drawBolt,
  input  logic                                   drawAlien,
  input  logic                                   drawShield,
  output logic [NUM_BOLTS-1:0]                   boltReturn,
  output logic [NUM_BOLTS-1:0]                   alienHit,
  output logic [NUM_BOLTS-1:0]                   shieldHit
);
  localparam int CW = bolt_pkg::COORD_W;

  for (genvar g = 0; g < NUM_BOLTS; g++) begin : g_slot
    bolt_slot_fsm #(
      .TOP_LIMIT_Y  (TOP_LIMIT_Y),
      .RETURN_FRAMES(RETURN_FRAMES)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .startOfFrame(startOfFrame),
      .boltFired   (boltFired[g]),
      .boltY       (boltY[g*CW +: CW]),
      .drawBolt    (drawBolt[g]),
      .drawAlien   (drawAlien),
      .drawShield  (drawShield),
      .boltReturn  (boltReturn[g]),
      .alienHit    (alienHit[g]),
      .shieldHit   (shieldHit[g])
    );
  end
endmodule

// File: tb/tb_bolt_return_ctrl.sv
// Bench for bolt_return_ctrl: two instances (1 and 3 recall frames) against a
// behavioural slot model, plus directed scenarios with literal expectations.
module tb_bolt_return_ctrl;
  localparam int NB = 4;

  logic clk = 0, rst = 0, sof = 0, da = 0, ds = 0;
  logic [NB-1:0]    fired = '0, db = '0;
  logic [NB*11-1:0] by;
  logic [NB-1:0]    ret1, a1, s1, ret3, a3, s3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bolt_return_ctrl #(.NUM_BOLTS(NB), .TOP_LIMIT_Y(8), .RETURN_FRAMES(1)) dut1 (
    .clk(clk), .reset(rst), .startOfFrame(sof), .boltFired(fired), .boltY(by),
    .drawBolt(db), .drawAlien(da), .drawShield(ds),
    .boltReturn(ret1), .alienHit(a1), .shieldHit(s1));

  bolt_return_ctrl #(.NUM_BOLTS(NB), .TOP_LIMIT_Y(8), .RETURN_FRAMES(3)) dut3 (
    .clk(clk), .reset(rst), .startOfFrame(sof), .boltFired(fired), .boltY(by),
    .drawBolt(db), .drawAlien(da), .drawShield(ds),
    .boltReturn(ret3), .alienHit(a3), .shieldHit(s3));

  // Model: per slot, whether it flies, which hit kind it has seen this flight
  // (0 none, 1 alien, 2 shield) and how many recall frames remain.
  int m_fly[2][NB], m_kind[2][NB], m_left[2][NB];
  logic [NB-1:0] e_ret[2], e_a[2], e_s[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NB; i++) begin
        m_fly[d][i] = 0; m_kind[d][i] = 0; m_left[d][i] = 0;
      end
      e_ret[d] = '0; e_a[d] = '0; e_s[d] = '0;
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      int rf = (d == 0) ? 1 : 3;
      for (int i = 0; i < NB; i++) begin
        int y = int'(by[i*11 +: 11]);
        bit a = db[i] && da;
        bit s = db[i] && ds && !da;
        e_a[d][i] = 1'b0;
        e_s[d][i] = 1'b0;
        if (m_left[d][i] > 0) begin
          if (sof) m_left[d][i]--;
        end else if (m_fly[d][i] != 0) begin
          if (m_kind[d][i] == 0 && a) begin
            m_kind[d][i] = 1; e_a[d][i] = 1'b1;
          end else if (m_kind[d][i] == 0 && s) begin
            m_kind[d][i] = 2; e_s[d][i] = 1'b1;
          end
          if (sof && (m_kind[d][i] != 0 || y >= 1024 || y < 8)) begin
            m_fly[d][i] = 0; m_left[d][i] = rf;
          end
        end else if (sof && fired[i]) begin
          m_fly[d][i] = 1; m_kind[d][i] = 0;
        end
        e_ret[d][i] = (m_left[d][i] > 0);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("m_ret_rf1", ret1, e_ret[0]);
    chk("m_alien_rf1", a1, e_a[0]);
    chk("m_shield_rf1", s1, e_s[0]);
    chk("m_ret_rf3", ret3, e_ret[1]);
    chk("m_alien_rf3", a3, e_a[1]);
    chk("m_shield_rf3", s3, e_s[1]);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic frame();
    sof = 1'b1; tick(); sof = 1'b0;
  endtask

  initial begin
    by = {NB{11'd200}};
    #1 rst = 1'b1;
    #2;
    chk("rst_ret", ret1, 4'b0000); chk("rst_alien", a1, 4'b0000); chk("rst_shield", s1, 4'b0000);
    @(negedge clk); rst = 1'b0;

    // Alien hit for 3 cycles gives one pulse, then a one-frame recall.
    fired = 4'b0001; frame();
    db = 4'b0001; da = 1'b1;
    tick(); chk("alien_first", a1, 4'b0001);
    tick(); chk("alien_repeat1", a1, 4'b0000);
    tick(); chk("alien_repeat2", a1, 4'b0000);
    db = '0; da = 1'b0;
    frame(); chk("ret_rise", ret1, 4'b0001);
    tick();  chk("ret_hold", ret1, 4'b0001);
    fired = '0; frame(); chk("ret_fall", ret1, 4'b0000);

    // Off-screen: low Y, wrapped Y, and the limit row itself.
    fired = 4'b0010; frame();
    by[11 +: 11] = 11'd5; fired = '0; frame();
    chk("off_low_ret", ret1, 4'b0010); chk("off_low_a", a1, 4'b0000); chk("off_low_s", s1, 4'b0000);
    frame();
    fired = 4'b0010; by[11 +: 11] = 11'd200; frame();
    by[11 +: 11] = 11'h7E2; fired = '0; frame();
    chk("off_wrap_ret", ret1, 4'b0010);
    frame();
    fired = 4'b0010; by[11 +: 11] = 11'd200; frame();
    by[11 +: 11] = 11'd8; frame(); chk("off_edge_noret", ret1, 4'b0000);
    by[11 +: 11] = 11'd5; fired = '0; frame(); frame();
    by[11 +: 11] = 11'd200;

    // Alien and shield on the same pixel: alien only.
    fired = 4'b0100; frame(); fired = '0;
    db = 4'b0100; da = 1'b1; ds = 1'b1;
    tick(); chk("pix_alien", a1, 4'b0100); chk("pix_shield", s1, 4'b0000);
    db = '0; da = 1'b0; ds = 1'b0; frame(); frame();

    // Shield only.
    fired = 4'b0100; frame(); fired = '0;
    db = 4'b0100; ds = 1'b1;
    tick(); chk("shield_only", s1, 4'b0100);
    db = '0; ds = 1'b0; frame(); frame();

    // Collision coinciding with the frame strobe.
    fired = 4'b1000; frame(); fired = '0;
    db = 4'b1000; da = 1'b1; sof = 1'b1;
    tick(); sof = 1'b0; db = '0; da = 1'b0;
    chk("sim_ret", ret1, 4'b1000); chk("sim_alien", a1, 4'b1000);
    frame();

    // Two slots hit together.
    fired = 4'b0011; frame(); fired = '0;
    db = 4'b0011; da = 1'b1;
    tick(); chk("dual_alien", a1, 4'b0011);
    db = '0; da = 1'b0; frame(); frame();

    // Three-frame recall on dut3, then re-fly while boltFired stays high.
    rst = 1'b1; tick(); rst = 1'b0;
    by = {NB{11'd200}};
    fired = 4'b0001; frame();
    by[0 +: 11] = 11'd5; frame(); chk("rf3_rise", ret3, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      tick(); frame();
      if (k < 2) chk("rf3_hold", ret3, 4'b0001);
      else       chk("rf3_fall", ret3, 4'b0000);
    end
    frame(); chk("rf3_refly", ret3, 4'b0000);
    frame(); chk("rf3_again", ret3, 4'b0001);

    // Asynchronous reset in the middle of a recall.
    tick();
    @(negedge clk); rst = 1'b1; #1;
    chk("arst_ret", ret3, 4'b0000); chk("arst_alien", a3, 4'b0000); chk("arst_shield", s3, 4'b0000);
    @(negedge clk); rst = 1'b0;
    db = 4'b0001; da = 1'b1;
    tick(); chk("arst_idle_ignore", a3, 4'b0000);
    db = '0; da = 1'b0;
    frame(); chk("arst_refly", ret3, 4'b0000);
    frame(); chk("arst_return", ret3, 4'b0001);

    // Random traffic, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      sof = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) fired = 4'($urandom);
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 39))
          0: by[i*11 +: 11] = 11'd5;
          1: by[i*11 +: 11] = 11'd8;
          2: by[i*11 +: 11] = 11'd7;
          3: by[i*11 +: 11] = 11'h7E2;
          4: by[i*11 +: 11] = 11'($urandom);
          5, 6, 7, 8, 9: by[i*11 +: 11] = 11'd200;
          default: ;
        endcase
      end
      db = 4'($urandom) & 4'($urandom);
      da = ($urandom_range(0, 3) == 0);
      ds = ($urandom_range(0, 2) == 0);
      rst = (n % 701 == 350);
      tick();
    end
    rst = 1'b0; sof = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
